// File: rtl/rangefinder_sopc_ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: owner-state encoding,
// master ids and the default fairness window.
package rangefinder_sopc_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam int HOLD_MAX_DEF = 4;
  localparam int DATA_W       = 32;
  localparam int BE_W         = 4;

  // Saturating increment used by the per-owner transfer counter.
  function automatic logic [3:0] hold_inc(input logic [3:0] cnt, input logic [3:0] lim);
    return (cnt >= lim) ? lim : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/rangefinder_sopc_ram_arbiter_if.sv
// One Avalon-MM style requester port: request side driven by the master,
// waitrequest and read return driven by the arbiter.
interface rangefinder_sopc_ram_arbiter_if
  import rangefinder_sopc_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 13
) ();

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/rangefinder_sopc_rr_arb2.sv
// Two-input round-robin grant with a per-owner hold counter; grant is
// combinational from requests and state, updated on every rising edge.
module rangefinder_sopc_rr_arb2
  import rangefinder_sopc_ram_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic [3:0] hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    case (state_q)
      ST_OWN0: begin
        if (req0 && (!req1 || hold_q < HOLD_LIM)) gnt0 = 1'b1;
        else if (req1)                            gnt1 = 1'b1;
      end
      ST_OWN1: begin
        if (req1 && (!req0 || hold_q < HOLD_LIM)) gnt1 = 1'b1;
        else if (req0)                            gnt0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          if (rr_q == MID_M1) gnt1 = 1'b1;
          else                gnt0 = 1'b1;
        end else if (req0) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end
      end
    endcase

    // No grant may leak out while reset is held, even with requests present.
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0) begin
      state_d = ST_OWN0;
      rr_d    = MID_M1;
      if (state_q != ST_OWN0) hold_d = 4'd1;
      else if (req1)          hold_d = hold_inc(hold_q, HOLD_LIM);
    end else if (gnt1) begin
      state_d = ST_OWN1;
      rr_d    = MID_M0;
      if (state_q != ST_OWN1) hold_d = 4'd1;
      else if (req0)          hold_d = hold_inc(hold_q, HOLD_LIM);
    end else begin
      state_d = ST_IDLE;
      hold_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= MID_M0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/rangefinder_sopc_ram_arbiter.sv
// Shares one on-chip RAM port between two masters; zero-wait accept when granted,
// read data returned one cycle later, losing master held off by waitrequest.
module rangefinder_sopc_ram_arbiter
  import rangefinder_sopc_ram_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int ADDR_W   = 13
) (
  input  logic                          clk,
  input  logic                          reset_n,
  rangefinder_sopc_ram_arbiter_if.slave m0,
  rangefinder_sopc_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]             ram_address,
  output logic [BE_W-1:0]               ram_byteenable,
  output logic [DATA_W-1:0]             ram_writedata,
  output logic                          ram_chipselect,
  output logic                          ram_write,
  output logic                          ram_clken,
  input  logic [DATA_W-1:0]             ram_readdata
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic rd_vld_q, rd_vld_d;
  logic rd_id_q, rd_id_d;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  rangefinder_sopc_rr_arb2 #(
    .HOLD_MAX (HOLD_MAX)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    if (gnt0) begin
      ram_address    = m0.address;
      ram_byteenable = m0.byteenable;
      ram_writedata  = m0.writedata;
      ram_write      = m0.write;
    end else if (gnt1) begin
      ram_address    = m1.address;
      ram_byteenable = m1.byteenable;
      ram_writedata  = m1.writedata;
      ram_write      = m1.write;
    end
    ram_chipselect = gnt0 | gnt1;
    ram_clken      = gnt0 | gnt1;
  end

  // Read+write together is executed as a write, so it never returns data.
  always_comb begin
    rd_vld_d = (gnt0 & m0.read & ~m0.write) | (gnt1 & m1.read & ~m1.write);
    rd_id_d  = rd_id_q;
    if (gnt1)      rd_id_d = MID_M1;
    else if (gnt0) rd_id_d = MID_M0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q <= 1'b0;
      rd_id_q  <= MID_M0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;
  assign m0.readdatavalid = rd_vld_q & (rd_id_q == MID_M0);
  assign m1.readdatavalid = rd_vld_q & (rd_id_q == MID_M1);

endmodule

// File: tb/tb_rangefinder_sopc_ram_arbiter.sv
// Directed vector bench for the two-master RAM arbiter with a behavioural RAM.
module tb_rangefinder_sopc_ram_arbiter;

  localparam logic [1:0] OP_IDL = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_RW  = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata = '0;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  rangefinder_sopc_ram_arbiter_if #(.ADDR_W(13)) m0_if ();
  rangefinder_sopc_ram_arbiter_if #(.ADDR_W(13)) m1_if ();

  rangefinder_sopc_ram_arbiter #(.HOLD_MAX(4), .ADDR_W(13)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  // Synchronous single-port RAM with byte lanes, registered q.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_clken && ram_chipselect) begin
      w = mem[ram_address];
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) w[8*b +: 8] = ram_writedata[8*b +: 8];
      mem[ram_address] <= w;
      ram_readdata     <= mem[ram_address];
    end
  end

  typedef struct {
    logic [1:0]  op0;  logic [12:0] a0; logic [3:0] be0; logic [31:0] wd0;
    logic [1:0]  op1;  logic [12:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic [1:0]  ew;   logic ecs; logic ewe; logic [12:0] eaddr;
    logic [1:0]  erdv; logic [31:0] erd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [1:0] op0, input logic [12:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
    input logic [1:0] op1, input logic [12:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
    input logic [1:0] ew, input logic ecs, input logic ewe, input logic [12:0] eaddr,
    input logic [1:0] erdv, input logic [31:0] erd);
    vec_t v;
    v.op0 = op0; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    v.op1 = op1; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.ew = ew; v.ecs = ecs; v.ewe = ewe; v.eaddr = eaddr;
    v.erdv = erdv; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic [1:0] op0, input logic [12:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
    input logic [1:0] op1, input logic [12:0] a1, input logic [3:0] be1, input logic [31:0] wd1);
    m0_if.read = op0[0]; m0_if.write = op0[1]; m0_if.address = a0;
    m0_if.byteenable = be0; m0_if.writedata = wd0;
    m1_if.read = op1[0]; m1_if.write = op1[1]; m1_if.address = a1;
    m1_if.byteenable = be1; m1_if.writedata = wd1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " wait0"}, 32'(m0_if.waitrequest), 32'd1);
    chk({tag, " wait1"}, 32'(m1_if.waitrequest), 32'd1);
    chk({tag, " cs"},    32'(ram_chipselect), 32'd0);
    chk({tag, " we"},    32'(ram_write), 32'd0);
    chk({tag, " clken"}, 32'(ram_clken), 32'd0);
    chk({tag, " rdv0"},  32'(m0_if.readdatavalid), 32'd0);
    chk({tag, " rdv1"},  32'(m1_if.readdatavalid), 32'd0);
  endtask

  initial begin
    // Tie arbitration from reset: m0 first, then m1.
    vecs.push_back(mk(OP_WR, 13'h20, 4'hF, 32'h11111111, OP_WR, 13'h21, 4'hF, 32'h22222222, 2'b10, 1, 1, 13'h20, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_WR, 13'h21, 4'hF, 32'h22222222, 2'b00, 1, 1, 13'h21, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b00, 0));
    vecs.push_back(mk(OP_RD, 13'h21, 0, 0, OP_RD, 13'h20, 0, 0, 2'b10, 1, 0, 13'h21, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_RD, 13'h20, 0, 0, 2'b00, 1, 0, 13'h20, 2'b01, 32'h22222222));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b10, 32'h11111111));
    // Write then read-back, no bubble.
    vecs.push_back(mk(OP_WR, 13'h10, 4'hF, 32'hDEADBEEF, OP_IDL, 0, 0, 0, 2'b00, 1, 1, 13'h10, 2'b00, 0));
    vecs.push_back(mk(OP_RD, 13'h10, 4'hF, 0, OP_IDL, 0, 0, 0, 2'b00, 1, 0, 13'h10, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b01, 32'hDEADBEEF));
    // Partial byte write on the top word.
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_WR, 13'h1FFF, 4'hF, 32'hFFFFFFFF, 2'b00, 1, 1, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_WR, 13'h1FFF, 4'h3, 32'h12345678, 2'b00, 1, 1, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_RD, 13'h1FFF, 4'hF, 0, 2'b00, 1, 0, 13'h1FFF, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b10, 32'hFFFF5678));
    // Read+write together behaves as a write.
    vecs.push_back(mk(OP_RW, 13'h30, 4'hF, 32'hA5A5A5A5, OP_IDL, 0, 0, 0, 2'b00, 1, 1, 13'h30, 2'b00, 0));
    vecs.push_back(mk(OP_RD, 13'h30, 4'hF, 0, OP_IDL, 0, 0, 0, 2'b00, 1, 0, 13'h30, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b01, 32'hA5A5A5A5));
    // Serve m1 once so the next tie prefers m0, then the hold window.
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_RD, 13'h20, 0, 0, 2'b00, 1, 0, 13'h20, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b10, 32'h11111111));
    vecs.push_back(mk(OP_RD, 13'h10, 0, 0, OP_WR, 13'h40, 4'hF, 32'hCAFEF00D, 2'b10, 1, 0, 13'h10, 2'b00, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(OP_RD, 13'h10, 0, 0, OP_WR, 13'h40, 4'hF, 32'hCAFEF00D, 2'b10, 1, 0, 13'h10, 2'b01, 32'hDEADBEEF));
    vecs.push_back(mk(OP_RD, 13'h10, 0, 0, OP_WR, 13'h40, 4'hF, 32'hCAFEF00D, 2'b01, 1, 1, 13'h40, 2'b01, 32'hDEADBEEF));
    vecs.push_back(mk(OP_RD, 13'h40, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 1, 0, 13'h40, 2'b00, 0));
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b01, 32'hCAFEF00D));
    // Alternating single reads, one per cycle.
    for (int k = 0; k < 16; k++) begin
      logic [1:0]  rdv;
      logic [31:0] rd;
      rdv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      rd  = (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'hDEADBEEF : 32'hFFFF5678);
      if (k % 2 == 0)
        vecs.push_back(mk(OP_RD, 13'h10, 0, 0, OP_IDL, 0, 0, 0, 2'b10, 1, 0, 13'h10, rdv, rd));
      else
        vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_RD, 13'h1FFF, 0, 0, 2'b01, 1, 0, 13'h1FFF, rdv, rd));
    end
    vecs.push_back(mk(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0, 2'b00, 0, 0, 13'h0, 2'b10, 32'hFFFF5678));

    // Reset with both masters requesting: everything held off.
    reset_n = 1'b0;
    drive(OP_RD, 13'h1, 4'hF, 0, OP_RD, 13'h2, 4'hF, 0);
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    drive(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.op0, v.a0, v.be0, v.wd0, v.op1, v.a1, v.be1, v.wd1);
      #1;
      if (v.op0 != OP_IDL) chk($sformatf("v%0d wait0", i), 32'(m0_if.waitrequest), 32'(v.ew[0]));
      if (v.op1 != OP_IDL) chk($sformatf("v%0d wait1", i), 32'(m1_if.waitrequest), 32'(v.ew[1]));
      chk($sformatf("v%0d cs", i),    32'(ram_chipselect), 32'(v.ecs));
      chk($sformatf("v%0d clken", i), 32'(ram_clken), 32'(v.ecs));
      chk($sformatf("v%0d we", i),    32'(ram_write), 32'(v.ewe));
      chk($sformatf("v%0d addr", i),  32'(ram_address), 32'(v.eaddr));
      chk($sformatf("v%0d rdv", i),   32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'(v.erdv));
      if (v.erdv[0]) chk($sformatf("v%0d rdata0", i), m0_if.readdata, v.erd);
      if (v.erdv[1]) chk($sformatf("v%0d rdata1", i), m1_if.readdata, v.erd);
    end

    // Reset right after an m1 read is accepted: its return must vanish.
    @(negedge clk);
    drive(OP_IDL, 0, 0, 0, OP_RD, 13'h20, 0, 0);
    #1 chk("midrst accept wait1", 32'(m1_if.waitrequest), 32'd0);
    @(posedge clk);
    #1;
    drive(OP_WR, 13'h3, 4'hF, 32'h1, OP_WR, 13'h4, 4'hF, 32'h2);
    reset_n = 1'b0;
    #1 chk_reset_outputs("async rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 chk($sformatf("in rst rdv1 %0d", k), 32'(m1_if.readdatavalid), 32'd0);
    end

    // Release with m0 writing: first edge after release must accept it.
    @(negedge clk);
    drive(OP_WR, 13'h50, 4'hF, 32'h5A5A5A5A, OP_IDL, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("release wait0", 32'(m0_if.waitrequest), 32'd0);
    chk("release cs",    32'(ram_chipselect), 32'd1);
    chk("release we",    32'(ram_write), 32'd1);
    chk("release rdv1",  32'(m1_if.readdatavalid), 32'd0);
    @(negedge clk);
    drive(OP_RD, 13'h50, 4'hF, 0, OP_IDL, 0, 0, 0);
    #1;
    chk("post rel wait0", 32'(m0_if.waitrequest), 32'd0);
    chk("post rel rdv1",  32'(m1_if.readdatavalid), 32'd0);
    chk("post rel rdv0",  32'(m0_if.readdatavalid), 32'd0);
    @(negedge clk);
    drive(OP_IDL, 0, 0, 0, OP_IDL, 0, 0, 0);
    #1;
    chk("post rel rd rdv0",  32'(m0_if.readdatavalid), 32'd1);
    chk("post rel rd data",  m0_if.readdata, 32'h5A5A5A5A);
    chk("post rel rd rdv1",  32'(m1_if.readdatavalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rangefinder_sopc_ram_arbiter.md
RANGEFINDER_SOPC_RAM_ARBITER -- requirements
Module: rangefinder_sopc_ram_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4: max consecutive accepted transfers for one master while the other waits (range 1..15).
REQ-002 Parameter ADDR_W, default 13: word-address width of shared RAM port.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_address / m1_address  in  ADDR_W  requester word address.
REQ-006 m0_byteenable / m1_byteenable  in  4  byte lanes.
REQ-007 m0_read, m0_write / m1_read, m1_write  in  1 each  transfer request; read and write both high is illegal.
REQ-008 m0_writedata / m1_writedata  in  32  write data.
REQ-009 m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle.
REQ-010 m0_readdata / m1_readdata  out  32  read data; m0_readdatavalid / m1_readdatavalid  out  1  read data qualifier.
REQ-011 ram_address  out  ADDR_W; ram_byteenable  out  4; ram_writedata  out  32; ram_chipselect, ram_write, ram_clken  out  1: drive one port of the dual-port on-chip RAM.
REQ-012 ram_readdata  in  32  RAM port q, valid one clk after address accepted.

Function
REQ-013 Accepted transfer = master request high and its waitrequest low at a rising clk edge; at most one accepted per cycle.
REQ-014 Grant is combinational from current requests, owner state, rr pointer and hold count; waitrequest of the granted master SHALL be low in the same cycle; ungranted requesting master waitrequest high; idle master waitrequest low is permitted only when it is not requesting (value don't-care).
REQ-015 States IDLE, OWN0, OWN1; reset state IDLE, rr pointer = m0 preferred.
REQ-016 IDLE: one requester -> grant it, next state OWNx; both -> grant rr-preferred master.
REQ-017 OWNx: owner requesting and (other idle or hold_cnt < HOLD_MAX) -> grant owner; other requesting and hold_cnt = HOLD_MAX -> grant other, switch state; no requests -> IDLE.
REQ-018 hold_cnt 4-bit: loads 1 on grant to a new owner, increments per accepted owner transfer while other requests, saturates at HOLD_MAX, clears in IDLE.
REQ-019 rr pointer SHALL point to the master not served by the most recent accepted transfer.
REQ-020 ram_chipselect = ram_clken = accepted transfer; ram_write = accepted write; address/byteenable/writedata muxed from granted master; all zero when no grant.
REQ-021 Read return: 1-cycle pipeline register records accepted read and master id; next cycle assert that master's readdatavalid for exactly one cycle with readdata = ram_readdata.
REQ-022 mX_readdata SHALL be driven from ram_readdata for both masters; only readdatavalid distinguishes.
REQ-023 Back-to-back reads, read-after-write, and master switch in consecutive cycles SHALL all sustain one transfer per cycle, no bubble.
REQ-024 Illegal read+write from a master: treated as write; no readdatavalid.

Reset
REQ-025 reset_n low: state IDLE, rr = m0, hold_cnt = 0, read pipeline cleared, both waitrequest = 1, both readdatavalid = 0, ram_chipselect/ram_write/ram_clken = 0.
REQ-026 Reset mid-read SHALL drop the pending readdatavalid; no spurious valid after reset release.
REQ-027 First grant possible in the first clk edge after reset_n deassertion.

Structure
REQ-028 Shared package: state encoding (IDLE=0, OWN0=1, OWN1=2), master-id constants, HOLD_MAX default.
REQ-029 One sub-module natural: rangefinder_sopc_rr_arb2 (two-input round-robin grant with hold counter); datapath mux and read pipeline stay in top.

Verification
REQ-030 m0 writes 0xDEADBEEF @0x0010 be=0xF, then reads @0x0010 -> waitrequest low both cycles, m0_readdatavalid one cycle after read with 0xDEADBEEF.
REQ-031 m0 and m1 request simultaneously from reset -> m0 granted first, m1 second; rr then prefers m0 on the next tie only after m1 served.
REQ-032 m0 continuous reads, m1 holds write, HOLD_MAX=4 -> 4 m0 accepts, then m1 accepted, m1 waitrequest high exactly 4 cycles.
REQ-033 m1 write be=0x3 data 0x12345678 over 0xFFFFFFFF @0x1FFF -> later read returns 0xFFFF5678; address wrap top word handled.
REQ-034 reset_n pulled low the cycle after m1 read accepted -> m1_readdatavalid never asserts; all outputs reach reset values asynchronously.
REQ-035 Alternating m0/m1 reads every cycle for 16 cycles -> 16 readdatavalids, correct master ids, no idle cycle on ram_chipselect.
